// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: state encodings and word-size derivation shared by the 74HC165/74HC595 shift-register blocks.
package shift_reg_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    DONE     = 3'd4
  } state_e;
  function automatic int data_size(input int width);
    return 1 << width;
  endfunction
endpackage

// File: rtl/shift_clk_timer.sv
// shift_clk_timer: 8-bit phase timer, reloaded with the phase length minus one on every state entry.
module shift_clk_timer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_restart,
  input  logic [7:0] i_load,
  output logic       o_expire
);
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d = i_restart ? i_load : cnt_q - {7'd0, cnt_q != 8'd0};
  assign o_expire = cnt_q == 8'd0;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/shift_reg_input.sv
// shift_reg_input: reads a 74HC165 chain into a parallel word on every change of i_enable_toggle.
// Define SHIFT_REG_INPUT_CHANGE_EN to add o_changed, flagging reads whose value differs from the previous one.
module shift_reg_input
  import shift_reg_pkg::*;
#(
  parameter int DATA_WIDTH  = 3,
  parameter int HALF_PERIOD = 1,
  localparam int DATA_SIZE  = data_size(DATA_WIDTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable_toggle,
  input  logic                 i_data_val,
  output logic                 o_load_n,
  output logic                 o_data_clock,
  output logic [DATA_SIZE-1:0] o_value,
  output logic                 o_valid,
  output logic                 o_busy
`ifdef SHIFT_REG_INPUT_CHANGE_EN
  ,
  output logic                 o_changed
`endif
);
  localparam logic [DATA_WIDTH:0] LAST_BIT = (DATA_WIDTH + 1)'(DATA_SIZE);
  localparam logic [7:0] PHASE_LOAD = 8'(HALF_PERIOD - 1);
  state_e state_q, state_d;
  logic last_q, last_d;
  logic [DATA_WIDTH:0] cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] sr_q, sr_d, value_q, value_d;
  logic load_n_q, dclk_q, valid_q, busy_q, expire;
  shift_clk_timer u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_restart (state_d != state_q),
    .i_load    (PHASE_LOAD),
    .o_expire  (expire)
  );
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE: begin
        if (i_enable_toggle != last_q) begin
          last_d  = i_enable_toggle;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD:     state_d = expire ? SHIFT_LO : LOAD;
      SHIFT_LO: begin
        // The bit is sampled at the end of the low phase so Q7 has settled since the last rising edge.
        if (expire) begin
          sr_d    = {sr_q[DATA_SIZE-2:0], i_data_val};
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_d == LAST_BIT) ? DONE : SHIFT_HI;
        end
      end
      SHIFT_HI: state_d = expire ? SHIFT_LO : SHIFT_HI;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so the pins switch on the same edge as the state.
  assign value_d = (state_d == DONE) ? sr_d : value_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      sr_q     <= '0;
      value_q  <= '0;
      load_n_q <= 1'b1;
      dclk_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      value_q  <= value_d;
      load_n_q <= state_d != LOAD;
      dclk_q   <= state_d == SHIFT_HI;
      valid_q  <= state_d == DONE;
      busy_q   <= state_d != IDLE;
    end
  end
  assign o_load_n     = load_n_q;
  assign o_data_clock = dclk_q;
  assign o_value      = value_q;
  assign o_valid      = valid_q;
  assign o_busy       = busy_q;
`ifdef SHIFT_REG_INPUT_CHANGE_EN
  logic changed_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) changed_q <= 1'b0;
    else changed_q <= (state_d == DONE) && (sr_d != value_q);
  end
  assign o_changed = changed_q;
`endif
endmodule

// File: tb/tb_shift_reg_input.sv
// tb_shift_reg_input: three DUT configurations, each reading a behavioural 74HC165 model.
module tb_shift_reg_input;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic [2:0] tog = 3'b000;
  logic [2:0] ld_n, dclk, valid, busy, dval;
  logic [7:0] v0, v1;
  logic [15:0] v2;
  logic [15:0] pv [3];
  logic [7:0] sr0, sr1;
  logic [15:0] sr2;
  int np0 = 0, np1 = 0, np2 = 0;
  int checks = 0, errors = 0;
`ifdef SHIFT_REG_INPUT_CHANGE_EN
  logic [2:0] chg;
  logic got_chg;
`endif
  assign dval = {sr2[15], sr1[7], sr0[7]};
  always @(posedge dclk[0] or negedge ld_n[0]) if (!ld_n[0]) sr0 <= pv[0][7:0]; else sr0 <= {sr0[6:0], 1'b0};
  always @(posedge dclk[1] or negedge ld_n[1]) if (!ld_n[1]) sr1 <= pv[1][7:0]; else sr1 <= {sr1[6:0], 1'b0};
  always @(posedge dclk[2] or negedge ld_n[2]) if (!ld_n[2]) sr2 <= pv[2]; else sr2 <= {sr2[14:0], 1'b0};
  always @(posedge dclk[0]) np0 <= np0 + 1;
  always @(posedge dclk[1]) np1 <= np1 + 1;
  always @(posedge dclk[2]) np2 <= np2 + 1;

  shift_reg_input #(.DATA_WIDTH(3), .HALF_PERIOD(1)) u0 (
    .i_clk(clk), .i_reset(rst), .i_enable_toggle(tog[0]), .i_data_val(dval[0]),
    .o_load_n(ld_n[0]), .o_data_clock(dclk[0]), .o_value(v0), .o_valid(valid[0]), .o_busy(busy[0])
`ifdef SHIFT_REG_INPUT_CHANGE_EN
    , .o_changed(chg[0])
`endif
  );
  shift_reg_input #(.DATA_WIDTH(3), .HALF_PERIOD(3)) u1 (
    .i_clk(clk), .i_reset(rst), .i_enable_toggle(tog[1]), .i_data_val(dval[1]),
    .o_load_n(ld_n[1]), .o_data_clock(dclk[1]), .o_value(v1), .o_valid(valid[1]), .o_busy(busy[1])
`ifdef SHIFT_REG_INPUT_CHANGE_EN
    , .o_changed(chg[1])
`endif
  );
  shift_reg_input #(.DATA_WIDTH(4), .HALF_PERIOD(1)) u2 (
    .i_clk(clk), .i_reset(rst), .i_enable_toggle(tog[2]), .i_data_val(dval[2]),
    .o_load_n(ld_n[2]), .o_data_clock(dclk[2]), .o_value(v2), .o_valid(valid[2]), .o_busy(busy[2])
`ifdef SHIFT_REG_INPUT_CHANGE_EN
    , .o_changed(chg[2])
`endif
  );

  typedef struct {
    int          sel;
    logic [15:0] par;
    logic [15:0] exp;
    int          lat;
    int          ld;
    int          hi;
    int          np;
  } vec_t;
  vec_t tv [7];

  function automatic logic [15:0] getv(input int sel);
    return (sel == 0) ? {8'h00, v0} : (sel == 1) ? {8'h00, v1} : v2;
  endfunction
  function automatic int npc(input int sel);
    return (sel == 0) ? np0 : (sel == 1) ? np1 : np2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic start(input int sel);
    @(negedge clk);
    tog[sel] = ~tog[sel];
  endtask

  // Counts posedges from the call; lat is the index of the first sample showing o_valid.
  task automatic read_check(input int sel, input logic [15:0] exp, input int lat, input int ld,
                            input int hi, input int npx, input string nm);
    int nld, nhi, n0, got_lat;
    logic moved;
    logic [15:0] vs;
    n0 = npc(sel);
    vs = getv(sel);
    nld = 0;
    nhi = 0;
    got_lat = -1;
    moved = 1'b0;
    for (int i = 1; i <= 200 && got_lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (valid[sel]) begin
        got_lat = i;
`ifdef SHIFT_REG_INPUT_CHANGE_EN
        got_chg = chg[sel];
`endif
      end else begin
        if (!ld_n[sel]) nld++;
        if (dclk[sel]) nhi++;
        if (getv(sel) != vs) moved = 1'b1;
      end
    end
    chk({nm, " latency"}, got_lat, lat);
    chk({nm, " value"}, getv(sel), exp);
    chk({nm, " value_held"}, moved, 0);
    if (ld >= 0) chk({nm, " load_cycles"}, nld, ld);
    if (hi >= 0) chk({nm, " clk_high_cycles"}, nhi, hi);
    if (npx >= 0) chk({nm, " clk_pulses"}, npc(sel) - n0, npx);
    @(posedge clk);
    #1;
    chk({nm, " busy_valid_fall"}, {busy[sel], valid[sel]}, 0);
  endtask

  initial begin
    int nb;
    tv[0] = '{0, 16'h00A5, 16'h00A5, 17, 1, 7, 7};
    tv[1] = '{1, 16'h003C, 16'h003C, 49, 3, 21, 7};
    tv[2] = '{2, 16'h8001, 16'h8001, 33, 1, 15, 15};
    tv[3] = '{0, 16'h005A, 16'h005A, 17, 1, 7, 7};
    tv[4] = '{0, 16'h00FF, 16'h00FF, 17, 1, 7, 7};
    tv[5] = '{0, 16'h0000, 16'h0000, 17, 1, 7, 7};
    tv[6] = '{2, 16'h7FFE, 16'h7FFE, 33, 1, 15, 15};
    pv[0] = '0;
    pv[1] = '0;
    pv[2] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst load_n", ld_n[0], 1);
    chk("rst data_clock", dclk[0], 0);
    chk("rst value", v0, 0);
    chk("rst valid", valid[0], 0);
    chk("rst busy", busy, 0);
    chk("rst value16", v2, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle after reset", busy, 0);
    for (int i = 0; i < 7; i++) begin
      pv[tv[i].sel] = tv[i].par;
      start(tv[i].sel);
      read_check(tv[i].sel, tv[i].exp, tv[i].lat, tv[i].ld, tv[i].hi, tv[i].np, $sformatf("vec%0d", i));
    end
    pv[0] = 16'h0033;
    start(0);
    repeat (4) @(negedge clk);
    tog[0] = ~tog[0];
    repeat (2) @(negedge clk);
    tog[0] = ~tog[0];
    read_check(0, 16'h0033, 11, -1, -1, -1, "dbl_toggle");
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (busy[0]) nb++;
    end
    chk("dbl_toggle no_read", nb, 0);
    pv[0] = 16'h0066;
    start(0);
    repeat (6) @(negedge clk);
    tog[0] = ~tog[0];
    read_check(0, 16'h0066, 11, -1, -1, -1, "one_toggle first");
    @(posedge clk);
    #1;
    chk("one_toggle restart busy", busy[0], 1);
    read_check(0, 16'h0066, 16, 0, 7, 7, "one_toggle second");
    pv[0] = 16'h00A5;
    start(0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst load_n", ld_n[0], 1);
    chk("midrst data_clock", dclk[0], 0);
    chk("midrst value", v0, 0);
    chk("midrst valid", valid[0], 0);
    chk("midrst busy", busy[0], 0);
    tog[0] = 1'b1;
    pv[0] = 16'h0096;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    read_check(0, 16'h0096, 17, 1, 7, 7, "post_rst");
`ifdef SHIFT_REG_INPUT_CHANGE_EN
    pv[0] = 16'h0012;
    start(0);
    read_check(0, 16'h0012, 17, 1, 7, 7, "chg1");
    chk("chg1 changed", got_chg, 1);
    start(0);
    read_check(0, 16'h0012, 17, 1, 7, 7, "chg2");
    chk("chg2 changed", got_chg, 0);
    pv[0] = 16'h0013;
    start(0);
    read_check(0, 16'h0013, 17, 1, 7, 7, "chg3");
    chk("chg3 changed", got_chg, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
